// File: rtl/moore_seq_gen.sv
// moore_seq_gen: Moore serial pattern generator feeding the serial sequence detectors.
// A start strobe in IDLE latches a PAT_W-bit pattern and a repeat count. The pattern
// is then shifted out MSB-first, one bit per clock, for the requested number of
// repeats. A one-cycle done pulse ends the transfer.
// Optional build macro SEQ_GEN_GAP_EN: inserts GAP_CYC idle cycles between repeats.
// All outputs are flops loaded from the next-state decode. Reset is asynchronous and
// active-low, so the outputs clear as soon as reset is asserted.

module moore_seq_gen #(
  parameter int unsigned PAT_W   = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             a,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam int unsigned GAP_W = 4;

  // Elaboration-time parameter range guards
  if (PAT_W < 2 || PAT_W > 32) begin : g_bad_pat_w
    $error("moore_seq_gen: PAT_W must be in 2..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("moore_seq_gen: CNT_W must be at least 1");
  end
  if (GAP_CYC < 1 || GAP_CYC > 15) begin : g_bad_gap
    $error("moore_seq_gen: GAP_CYC must be in 1..15");
  end

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd3
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
`ifdef SEQ_GEN_GAP_EN
  logic [GAP_W-1:0]   gap_q, gap_d;
`endif
  logic               a_d, a_valid_d, busy_d, done_d;

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
`ifdef SEQ_GEN_GAP_EN
      gap_q   <= '0;
`endif
      a       <= 1'b0;
      a_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
`ifdef SEQ_GEN_GAP_EN
      gap_q   <= gap_d;
`endif
      a       <= a_d;
      a_valid <= a_valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state, datapath update and Moore output decode of the next state
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
`ifdef SEQ_GEN_GAP_EN
    gap_d     = gap_q;
`endif
    a_d       = 1'b0;
    a_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (repeat_n != '0) begin
            pat_d   = pattern;
            cnt_d   = repeat_n;
            idx_d   = IDX_W'(PAT_W - 1);
            state_d = S_SEND;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_SEND: begin
        if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else begin
          // Last bit of this repeat: the counter saturates at zero
          cnt_d = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;
          if (cnt_d != '0) begin
            idx_d = IDX_W'(PAT_W - 1);
`ifdef SEQ_GEN_GAP_EN
            gap_d   = GAP_W'(GAP_CYC - 1);
            state_d = S_GAP;
`else
            state_d = S_SEND;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end

`ifdef SEQ_GEN_GAP_EN
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          state_d = S_SEND;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs depend only on the state being entered, so they are pure Moore once registered
    a_valid_d = (state_d == S_SEND);
    a_d       = (state_d == S_SEND) ? pat_d[idx_d] : 1'b0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

endmodule
